// File: rtl/imem_refill.sv
// imem_refill: line-refill controller upstream of the L1 instruction cache.
// On a miss it latches the line address of pc, reads the line from the memory bus
// as BEATS sequential beats, assembles them and pulses b_dv for one cycle. A refill
// whose requesting address changes mid-flight still completes on the bus but is
// never delivered.
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   rst_n   synchronous active-low reset
//   pc      current fetch address (same value driving the cache)
//   b_rd    cache miss request
//   b_data  assembled line, beat k in [BUS_W*k +: BUS_W]
//   b_dv    one-cycle pulse, b_data valid for the line at pc
//   m_addr  beat read address, BUS_W/8-byte aligned
//   m_rd    beat read request, held until acknowledged
//   m_data  beat read data
//   m_dv    beat acknowledge, sampled only while m_rd is high
module imem_refill #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BUS_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       pc,
  input  logic              b_rd,
  output logic [LINE_W-1:0] b_data,
  output logic              b_dv,
  output logic [63:0]       m_addr,
  output logic              m_rd,
  input  logic [BUS_W-1:0]  m_data,
  input  logic              m_dv
);

  localparam int unsigned BEATS = LINE_W / BUS_W;
  localparam int unsigned OFFS  = $clog2(LINE_W / 8);
  localparam int unsigned BOFFS = $clog2(BUS_W / 8);
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TAGW  = 64 - OFFS;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [TAGW-1:0]     line_q, line_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                abort_q, abort_d;
  logic [LINE_W-1:0]   data_q, data_d;

  logic [TAGW-1:0]     pc_line;
  logic                mismatch;
  logic                last_beat;
  logic                unused_pc;

  assign pc_line   = pc[63:OFFS];
  assign unused_pc = ^pc[OFFS-1:0];
  assign mismatch  = !b_rd || (pc_line != line_q);
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // Outputs are pure decodes of registered state; b_dv additionally qualifies
  // on the live address so a stale line is never handed to the cache.
  assign m_rd   = (state_q == StBusy);
  assign m_addr = (state_q == StBusy)
                  ? ({line_q, {OFFS{1'b0}}} | (64'(beat_q) << BOFFS))
                  : 64'd0;
  assign b_dv   = (state_q == StDone) && !mismatch;
  assign b_data = data_q;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    abort_d = abort_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (b_rd) begin
          line_d  = pc_line;
          beat_d  = '0;
          abort_d = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Sticky: the bus transaction runs to completion, delivery is dropped.
        if (mismatch) abort_d = 1'b1;
        if (m_dv) begin
          data_d[BUS_W*beat_q +: BUS_W] = m_data;
          if (BEATS > 1) beat_d = beat_q + BW'(1);
          if (last_beat) state_d = (abort_q || mismatch) ? StIdle : StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      line_q  <= '0;
      beat_q  <= '0;
      abort_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      abort_q <= abort_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_imem_refill.sv
// Bench for imem_refill (LINE_W=256, BUS_W=64): directed refill scenarios with a
// scoreboard of expected beat addresses and delivered lines.
module tb_imem_refill;

  logic         clk;
  logic         rst_n;
  logic [63:0]  pc;
  logic         b_rd;
  logic [255:0] b_data;
  logic         b_dv;
  logic [63:0]  m_addr;
  logic         m_rd;
  logic [63:0]  m_data;
  logic         m_dv;

  imem_refill #(.LINE_W(256), .BUS_W(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc     (pc),
    .b_rd   (b_rd),
    .b_data (b_data),
    .b_dv   (b_dv),
    .m_addr (m_addr),
    .m_rd   (m_rd),
    .m_data (m_data),
    .m_dv   (m_dv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wait_n   = 0;
  int wait_cnt = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int dv_cnt   = 0;
  int dv_cyc   = 0;
  bit mem_en   = 1'b1;
  bit spur     = 1'b0;
  bit prev_rd  = 1'b0;
  bit prev_wait = 1'b0;
  logic [63:0]  prev_addr = '0;
  logic [63:0]  addr_q[$];
  logic [255:0] line_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [63:0] base);
    return {base + 64'd24, base + 64'd16, base + 64'd8, base};
  endfunction

  task automatic push_addrs(input logic [63:0] base);
    for (int k = 0; k < 4; k++) addr_q.push_back(base + 64'(8 * k));
  endtask

  // One clock cycle: drive the memory model just after a falling edge, sample
  // outputs 1ns later, then advance to the next falling edge.
  task automatic cycle();
    logic [63:0]  ea;
    logic [255:0] el;
    if (m_rd === 1'b1 && mem_en) begin
      m_dv   = (wait_cnt == wait_n);
      m_data = m_addr;
    end else if (m_rd === 1'b0 && spur) begin
      m_dv   = 1'b1;
      m_data = 64'hDEAD;
    end else begin
      m_dv   = 1'b0;
      m_data = '0;
    end
    #1;
    if (m_rd === 1'b1 && !prev_rd) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (prev_wait) begin
      check("hold_m_rd", 256'(m_rd), 256'(1'b1));
      check("hold_m_addr", 256'(m_addr), 256'(prev_addr));
    end
    if (m_rd === 1'b1 && m_dv) begin
      ea = (addr_q.size() != 0) ? addr_q.pop_front() : '1;
      check("beat_addr", 256'(m_addr), 256'(ea));
      wait_cnt = 0;
    end else if (m_rd === 1'b1) begin
      wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    prev_wait = (m_rd === 1'b1) && !m_dv && rst_n;
    prev_addr = m_addr;
    prev_rd   = (m_rd === 1'b1);
    if (b_dv === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
      el = (line_q.size() != 0) ? line_q.pop_front() : '1;
      check("line_data", b_data, el);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_dv(input int limit, input bit drop);
    int d0;
    d0 = dv_cnt;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (dv_cnt != d0) break;
    end
    check("dv_seen", 256'(dv_cnt != d0), 256'(1'b1));
    if (drop) b_rd = 1'b0;
  endtask

  int c0, d0, d1, r0;
  logic [255:0] exp_line;

  initial begin
    rst_n = 1'b0; pc = '0; b_rd = 1'b0; m_dv = 1'b0; m_data = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    check("rst_m_rd", 256'(m_rd), 256'(1'b0));
    check("rst_m_addr", 256'(m_addr), 256'(0));
    check("rst_b_dv", 256'(b_dv), 256'(1'b0));
    check("rst_b_data", b_data, 256'(0));

    // Basic zero-wait refill
    push_addrs(64'h8000_0000);
    line_q.push_back(line_of(64'h8000_0000));
    pc = 64'h8000_0014; b_rd = 1'b1; c0 = cyc;
    run_until_dv(20, 1'b1);
    check("basic_rd_cycle", 256'(rise_cyc - c0), 256'(1));
    check("basic_dv_cycle", 256'(dv_cyc - c0), 256'(5));
    check("basic_beats_done", 256'(addr_q.size()), 256'(0));

    // Two wait states per beat
    wait_n = 2;
    push_addrs(64'h8000_0000);
    line_q.push_back(line_of(64'h8000_0000));
    pc = 64'h8000_0014; b_rd = 1'b1; c0 = cyc;
    run_until_dv(40, 1'b1);
    check("wait_dv_cycle", 256'(dv_cyc - c0), 256'(13));
    wait_n = 0;
    cycle();

    // Redirect after beat 1: old line completes, no delivery, new refill follows
    push_addrs(64'h8000_0000);
    push_addrs(64'h8000_1000);
    line_q.push_back(line_of(64'h8000_1000));
    pc = 64'h8000_0000; b_rd = 1'b1; c0 = cyc; d0 = dv_cnt;
    cycle(); cycle(); cycle();
    pc = 64'h8000_1000;
    cycle(); cycle(); cycle();
    check("redir_no_dv", 256'(dv_cnt), 256'(d0));
    check("redir_old_beats", 256'(addr_q.size()), 256'(4));
    run_until_dv(20, 1'b1);
    check("redir_new_rd_cycle", 256'(rise_cyc - c0), 256'(6));
    check("redir_dv_cycle", 256'(dv_cyc - c0), 256'(10));
    cycle();

    // Reset during beat 2 with b_rd held: restart from beat 0
    addr_q.push_back(64'h8000_0040);
    addr_q.push_back(64'h8000_0048);
    push_addrs(64'h8000_0040);
    line_q.push_back(line_of(64'h8000_0040));
    pc = 64'h8000_0040; b_rd = 1'b1; c0 = cyc;
    cycle(); cycle(); cycle();
    mem_en = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; mem_en = 1'b1;
    check("midrst_m_rd", 256'(m_rd), 256'(1'b0));
    check("midrst_b_dv", 256'(b_dv), 256'(1'b0));
    check("midrst_m_addr", 256'(m_addr), 256'(0));
    check("midrst_b_data", b_data, 256'(0));
    run_until_dv(20, 1'b1);
    check("midrst_rd_cycle", 256'(rise_cyc - c0), 256'(5));
    check("midrst_dv_cycle", 256'(dv_cyc - c0), 256'(9));

    // Spurious m_dv in IDLE and DONE
    spur = 1'b1;
    push_addrs(64'h8000_0080);
    exp_line = line_of(64'h8000_0080);
    line_q.push_back(exp_line);
    pc = 64'h8000_0080; b_rd = 1'b1; c0 = cyc;
    run_until_dv(20, 1'b1);
    check("spur_dv_cycle", 256'(dv_cyc - c0), 256'(5));
    r0 = rise_cnt;
    cycle(); cycle(); cycle();
    check("spur_b_data", b_data, exp_line);
    check("spur_no_rd", 256'(rise_cnt), 256'(r0));
    check("spur_m_rd", 256'(m_rd), 256'(1'b0));
    spur = 1'b0;

    // Request dropped in the DONE cycle suppresses b_dv
    push_addrs(64'h8000_0100);
    pc = 64'h8000_0100; b_rd = 1'b1; d0 = dv_cnt;
    cycle(); cycle(); cycle(); cycle(); cycle();
    b_rd = 1'b0;
    cycle(); cycle();
    check("done_drop_no_dv", 256'(dv_cnt), 256'(d0));
    check("done_drop_beats", 256'(addr_q.size()), 256'(0));

    // Back-to-back misses
    push_addrs(64'h8000_0000);
    line_q.push_back(line_of(64'h8000_0000));
    push_addrs(64'h8000_0020);
    line_q.push_back(line_of(64'h8000_0020));
    pc = 64'h8000_0000; b_rd = 1'b1;
    run_until_dv(20, 1'b0);
    d1 = dv_cyc;
    pc = 64'h8000_0020;
    run_until_dv(20, 1'b1);
    check("b2b_rd_cycle", 256'(rise_cyc - d1), 256'(2));
    check("b2b_dv_cycle", 256'(dv_cyc - d1), 256'(6));
    cycle(); cycle();

    check("scoreboard_empty", 256'(addr_q.size() + line_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_refill.md
# imem_refill

Line-refill controller sitting directly upstream of the L1 instruction cache. On a cache miss (`b_rd` high) it latches the missing line address, fetches the line from the memory bus as `LINE_W/BUS_W` sequential read beats, assembles them into one line, and presents it to the cache with a single-cycle `b_dv` pulse. A refill whose requesting address changes mid-flight is completed on the bus but discarded, never delivered.

## Interface
- `LINE_W`, default 256: cache line width in bits; must equal the cache's line width; power of two.
- `BUS_W`, default 64: memory bus data width in bits; power of two, `BUS_W <= LINE_W`.
- Derived: `BEATS = LINE_W/BUS_W`; `OFFS = log2(LINE_W/8)`; `BOFFS = log2(BUS_W/8)`.
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `pc`  in  64  current fetch address, the same value driving the cache.
- `b_rd`  in  1  cache miss request (the cache drives `~hit`).
- `b_data`  out  LINE_W  assembled line; beat k in `[BUS_W*k +: BUS_W]`.
- `b_dv`  out  1  one-cycle pulse: `b_data` valid for the line at `pc`.
- `m_addr`  out  64  beat read address, `BUS_W/8`-byte aligned.
- `m_rd`  out  1  beat read request; held high until acknowledged.
- `m_data`  in  BUS_W  read data, valid when `m_dv` is high.
- `m_dv`  in  1  beat acknowledge; sampled only while `m_rd` is high.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `m_rd=0`, `b_dv=0`. If `b_rd=1`: latch `line = pc[63:OFFS]`, clear `beat`, clear `abort`, go BUSY.
- BUSY: `m_rd=1`, `m_addr = {line, beat, BOFFS zero bits}`.
  - On `m_dv=1`: write `m_data` into `b_data[BUS_W*beat +: BUS_W]` and increment `beat`.
  - If the accepted beat is `BEATS-1`: go DONE if `abort=0`, otherwise go IDLE.
- Abort: in BUSY, whenever `b_rd=0` or `pc[63:OFFS] != line`, set `abort` (sticky until the next IDLE exit).
  - An outstanding beat is never cancelled; remaining beats are still fetched so that bus transactions always complete in full.
- DONE: `b_dv=1` for exactly one cycle, then IDLE.
  - If in the DONE cycle `pc[63:OFFS] != line` or `b_rd=0`, `b_dv` is forced to 0. The cache must never receive a line tagged with the wrong address.
- `m_dv` outside BUSY is ignored; no state or data changes.
- `b_data` holds its last value outside DONE. Its contents are don't-care unless `b_dv=1`.
- `beat` is `log2(BEATS)` bits and wraps to 0 after the last beat. With `BEATS=1` the counter is absent and a single beat ends BUSY.

## Timing
- Reset (`rst_n=0` at an edge): state IDLE, `m_rd=0`, `m_addr=0`, `b_dv=0`, `b_data=0`, `beat=0`, `abort=0`.
  - Reset mid-refill abandons the transaction immediately. The memory side must tolerate a dropped `m_rd`.
- Outputs `m_rd`, `m_addr` and `b_dv` are registered or pure state decodes; none depends combinationally on `m_dv`.
- Miss seen at edge 0 → `m_rd` high in cycle 1.
  - With a zero-wait memory (`m_dv` in the same cycle `m_rd` rises), the last beat is accepted at the end of cycle `BEATS`.
  - `b_dv` is high in cycle `BEATS+1`.
  - Minimum miss latency is `BEATS+2` cycles; each memory wait state adds one cycle per beat.
- After a DONE, the cache installs the line at the same edge and `b_rd` falls. IDLE in the next cycle therefore sees no request.
- Back-to-back misses: a new refill starts the cycle after DONE or an abort-to-IDLE, with no extra bubble.

## Test plan
- Basic refill (`LINE_W=256`, `BUS_W=64`), zero-wait memory returning `m_data = m_addr`, `pc=0x8000_0014`, `b_rd=1`:
  - `m_addr` sequence 0x8000_0000, 0x8000_0008, 0x8000_0010, 0x8000_0018.
  - `b_dv` pulses once in cycle 5.
  - `b_data = {0x8000_0018, 0x8000_0010, 0x8000_0008, 0x8000_0000}`.
- Wait states: memory delays each `m_dv` by 2 cycles:
  - `m_addr`/`m_rd` stay stable while waiting.
  - `b_dv` is in cycle 13; data is identical to the basic refill.
- Redirect mid-refill: `pc` changes to 0x8000_1000 after beat 1:
  - All 4 beats of line 0x8000_0000 still complete.
  - No `b_dv` occurs.
  - A new refill then starts with `m_addr=0x8000_1000`.
- Reset mid-refill: `rst_n=0` for one edge during beat 2:
  - Next cycle `m_rd=0`, `b_dv=0`, state IDLE.
  - With `b_rd=1` held, the refill restarts at beat 0.
- Spurious `m_dv`: pulse `m_dv` with data 0xDEAD in IDLE and in DONE:
  - `beat`, state and `b_data` are unchanged.
  - No extra `m_rd` is issued.
- Back-to-back misses at 0x8000_0000 then 0x8000_0020 (`b_rd` high in the cycle after DONE):
  - The second refill's first `m_rd` follows DONE by exactly one cycle.
  - Two `b_dv` pulses occur, each carrying the correct line.
